// File: rtl/seg_hex_array.sv
// seg_hex_array: multi-digit hex seven-segment driver with leading-zero blanking and per-digit blink
module seg_hex_array #(
    parameter int DIGITS    = 8,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blink_en,
    input  logic                  lz_en,
    output logic [8*DIGITS-1:0]   seg_out,
    output logic                  blink_phase
);
    localparam int CW = $clog2(BLINK_DIV);

    logic [4*DIGITS-1:0] val;
    logic [DIGITS-1:0]   dp, bl, blank;
    logic [CW-1:0]       cnt;
    logic [8*DIGITS-1:0] seg_nxt;
    logic                zero;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'b0000001;
            4'h1: hex7 = 7'b1001111;
            4'h2: hex7 = 7'b0010010;
            4'h3: hex7 = 7'b0000110;
            4'h4: hex7 = 7'b1001100;
            4'h5: hex7 = 7'b0100100;
            4'h6: hex7 = 7'b0100000;
            4'h7: hex7 = 7'b0001111;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0000100;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b1100000;
            4'hC: hex7 = 7'b0110001;
            4'hD: hex7 = 7'b1000010;
            4'hE: hex7 = 7'b0110000;
            default: hex7 = 7'b0111000;
        endcase
    endfunction

    // held display value, decimal points and blink mask; reset wins over load
    always_ff @(posedge clk) begin
        if (!rst) begin
            val <= '0;
            dp  <= '0;
            bl  <= '0;
        end else if (load) begin
            val <= din;
            dp  <= dp_in;
            bl  <= blink_en;
        end
    end

    // free-running blink divider, phase flips on every wrap
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt         <= '0;
            blink_phase <= 1'b0;
        end else if (cnt == CW'(BLINK_DIV - 1)) begin
            cnt         <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // per-digit pattern: zero run tracked from the top digit down; digit 0 never blanks
    always_comb begin
        zero    = 1'b1;
        blank   = '0;
        seg_nxt = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero              = zero & (val[4*i+:4] == 4'd0);
            blank[i]          = lz_en & zero & (i != 0);
            seg_nxt[8*i+:8]   = (blink_phase & bl[i]) ? 8'hFF
                              : {blank[i] ? 7'h7F : hex7(val[4*i+:4]), ~dp[i]};
        end
    end

    // registered segment outputs, all dark in reset
    always_ff @(posedge clk) begin
        if (!rst) seg_out <= '1;
        else      seg_out <= seg_nxt;
    end
endmodule

// File: tb/tb_seg_hex_array.sv
// tb_seg_hex_array: directed stimulus with a cycle-tagged scoreboard for seg_hex_array
module tb_seg_hex_array;
    logic        clk = 1'b0;
    logic        rst, load, lz_en, blink_phase;
    logic [15:0] din;
    logic [3:0]  dp_in, blink_en;
    logic [31:0] seg_out;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        int          c;
        logic [31:0] seg;
        bit          cp;
        bit          ph;
        string       nm;
    } exp_t;
    exp_t q[$];

    seg_hex_array #(.DIGITS(4), .BLINK_DIV(4)) dut (
        .clk(clk), .rst(rst), .load(load), .din(din), .dp_in(dp_in),
        .blink_en(blink_en), .lz_en(lz_en), .seg_out(seg_out), .blink_phase(blink_phase)
    );

    always #5 clk = ~clk;

    // number of rising edges seen so far
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [31:0] s, input bit cp, input bit ph, input string nm);
        exp_t e;
        e.c = c; e.seg = s; e.cp = cp; e.ph = ph; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // monitor: compares queued expectations on the falling edge of their cycle
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].c <= cyc) begin
            exp_t e;
            e = q.pop_front();
            total++;
            if (e.c < cyc) begin
                bad++;
                $display("FAIL %s missed cyc=%0d", e.nm, e.c);
            end else if (seg_out !== e.seg || (e.cp && blink_phase !== e.ph)) begin
                bad++;
                $display("FAIL %s cyc=%0d seg_out=%h want=%h phase=%b want=%b",
                         e.nm, cyc, seg_out, e.seg, blink_phase, e.ph);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; load = 1'b1; din = 16'hFFFF; dp_in = 4'hF; blink_en = 4'hF; lz_en = 1'b0;
        push(1, 32'hFFFFFFFF, 1, 0, "rst1");
        push(2, 32'hFFFFFFFF, 1, 0, "rst2");
        wait_cyc(2);
        rst = 1'b1; load = 1'b0; dp_in = 4'h0; blink_en = 4'h0;
        push(3, 32'h03030303, 1, 0, "post_rst");
        push(4, 32'h03030303, 0, 0, "latency_hold");
        wait_cyc(3);
        load = 1'b1; din = 16'h12AF;
        wait_cyc(4);
        load = 1'b0;
        push(5, 32'h9F251171, 0, 0, "hex_12af");
        wait_cyc(5);
        lz_en = 1'b1; load = 1'b1; din = 16'h0050;
        push(6, 32'h9F251171, 0, 0, "lz_no_zeros");
        wait_cyc(6);
        load = 1'b0;
        push(7, 32'hFFFF4903, 0, 0, "lz_0050");
        wait_cyc(7);
        load = 1'b1; din = 16'h0000;
        wait_cyc(8);
        load = 1'b0;
        push(9, 32'hFFFFFF03, 0, 0, "lz_0000");
        wait_cyc(9);
        load = 1'b1; dp_in = 4'b1000;
        wait_cyc(10);
        load = 1'b0;
        push(11, 32'hFEFFFF03, 0, 0, "lz_dp3");
        wait_cyc(11);
        lz_en = 1'b0;
        push(12, 32'h02030303, 0, 0, "lz_live_off");
        wait_cyc(12);
        load = 1'b1; din = 16'h1234; dp_in = 4'h0; blink_en = 4'b0001;
        // phase after edge e is ((e-2)/4)%2; the pattern at edge e uses the phase after e-1
        for (int e = 14; e <= 24; e++)
            push(e, {24'h9F250D, (((e - 3) / 4) % 2 == 1) ? 8'hFF : 8'h99}, 1, ((e - 2) / 4) % 2 == 1, "blink");
        wait_cyc(13);
        load = 1'b0;
        wait_cyc(24);
        rst = 1'b0;
        push(25, 32'hFFFFFFFF, 1, 0, "mid_blink_rst");
        wait_cyc(25);
        rst = 1'b1;
        for (int e = 26; e <= 32; e++)
            push(e, 32'h03030303, 1, e >= 29, "no_blink_after_rst");
        wait_cyc(32);
        load = 1'b1; din = 16'h0001;
        push(34, 32'h0303039F, 0, 0, "burst1");
        push(35, 32'h03030325, 0, 0, "burst2");
        push(36, 32'h0303030D, 0, 0, "burst3");
        wait_cyc(33);
        din = 16'h0002;
        wait_cyc(34);
        din = 16'h0003;
        wait_cyc(35);
        load = 1'b0;
        wait_cyc(40);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            total++;
            bad++;
            $display("FAIL %s never checked cyc=%0d", e.nm, e.c);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg_hex_array.md
SEG_HEX_ARRAY -- requirements
Module: seg_hex_array

Interface
REQ-001 Parameter DIGITS, default 8, number of seven-segment digits (legal range 1..8).
REQ-002 Parameter BLINK_DIV, default 25000000, clock cycles per blink half-period (legal: >=2).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 load  input  1  when high, latch din/dp_in/blink_en on this edge.
REQ-006 din  input  4*DIGITS  hex value; digit i = din[4i+3:4i], digit 0 least significant.
REQ-007 dp_in  input  DIGITS  decimal point request per digit, 1 = lit.
REQ-008 blink_en  input  DIGITS  per-digit blink enable, 1 = digit blinks.
REQ-009 lz_en  input  1  leading-zero blanking mode, sampled live each cycle (not latched).
REQ-010 seg_out  output  8*DIGITS  digit i at seg_out[8i+7:8i]; bit7=a .. bit1=g, bit0=dp; active-low (0 = segment lit).
REQ-011 blink_phase  output  1  current blink phase, 1 = blinking digits dark.

Function
REQ-012 Held registers val, dp, bl SHALL load din, dp_in, blink_en on any rising edge with rst=1 and load=1; otherwise hold.
REQ-013 seg_out SHALL be registered, computed from held registers, lz_en and blink_phase: load sampled at edge k -> new pattern visible after edge k+1 (2-edge latency).
REQ-014 Hex decode, a..g bits (0 = lit): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-015 dp bit of digit i SHALL equal ~dp[i].
REQ-016 When lz_en=1, digit i (i>=1) SHALL be blanked if it and every more-significant digit hold 0; digit 0 SHALL never be blanked.
REQ-017 Blanked digit: a..g all 1; dp bit still follows REQ-015.
REQ-018 Blink counter SHALL count 0..BLINK_DIV-1, wrap to 0, and toggle blink_phase on each wrap; free-running, independent of load.
REQ-019 When blink_phase=1 and bl[i]=1, digit i SHALL be 8'hFF (overrides decode, blanking and dp).
REQ-020 Digits with bl[i]=0 SHALL be unaffected by blink_phase.
REQ-021 load asserted on consecutive cycles SHALL take the latest value each edge; no handshake or backpressure.
REQ-022 Counter width SHALL be $clog2(BLINK_DIV); no overflow beyond BLINK_DIV-1.

Reset
REQ-023 On rising edge with rst=0: val=0, dp=0, bl=0, counter=0, blink_phase=0, seg_out all 8'hFF.
REQ-024 Reset SHALL take priority over load in the same cycle.
REQ-025 First edge after rst returns to 1 SHALL compute seg_out from reset register values (val=0).

Verification (DIGITS=4, BLINK_DIV=4)
REQ-026 rst=0 for 2 edges with load=1, din=16'hFFFF -> seg_out=32'hFFFFFFFF, blink_phase=0; release, lz_en=0 -> next edge seg_out=32'h03030303.
REQ-027 load din=16'h12AF, dp_in=0, blink_en=0, lz_en=0 -> two edges later seg_out=32'h9F251171.
REQ-028 lz_en=1, load din=16'h0050 -> seg_out=32'hFFFF4903; din=16'h0000 -> 32'hFFFFFF03; dp_in=4'b1000, din=0 -> digit3=8'hFE.
REQ-029 load din=16'h1234, blink_en=4'b0001 -> blink_phase toggles every 4 edges; seg_out[7:0] alternates 8'h99 / 8'hFF with 8-cycle period, upper digits constant 8'h9F250D.
REQ-030 Mid-blink, rst=0 one edge -> counter, blink_phase=0, seg_out=all FF; bl cleared so no further blinking.
REQ-031 load pulses on 3 consecutive edges with din 16'h0001, 0002, 0003 -> seg_out steps 32'h0303039F, 03030325, 0303030D one edge apart.
